// File: rtl/fifo_bus_pkg.sv
// Shared definitions for the bus_sel request fabric: default sizes, FSM encoding
// and a one-hot helper used by the grant checker.
package fifo_bus_pkg;

  localparam int PORT_NUM_DEF = 6;
  localparam int DATA_W_DEF   = 32;
  localparam int TIMEOUT_DEF  = 255;
  localparam int IDLE_CNT_W   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // True when at most one bit of vec is set.
  function automatic logic is_onehot0(input logic [31:0] vec);
    return ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/fifo_bus_sel_arbiter_chk.sv
// Simulation-only protocol checker for the arbiter grant outputs.
module fifo_bus_sel_arbiter_chk
  import fifo_bus_pkg::*;
#(
  parameter int PORT_NUM = PORT_NUM_DEF
) (
  input logic                clk,
  input logic                rst_n,
  input logic [PORT_NUM-1:0] gnt,
  input logic                busy
);

  gnt_onehot0_a : assert property (@(posedge clk) disable iff (!rst_n)
    is_onehot0(32'(gnt)));

  busy_gnt_a : assert property (@(posedge clk) disable iff (!rst_n)
    busy == (gnt != '0));

endmodule

// File: rtl/fifo_bus_sel_arbiter_rr_pick_onehot.sv
// Round-robin winner search: first set request bit above rr_ptr, wrapping to 0,
// returned both as a one-hot vector and as an index.
module rr_pick_onehot
  import fifo_bus_pkg::*;
#(
  parameter int PORT_NUM = PORT_NUM_DEF,
  parameter int IDX_W    = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic [PORT_NUM-1:0] req,
  input  logic [IDX_W-1:0]    rr_ptr,
  output logic [PORT_NUM-1:0] onehot,
  output logic [IDX_W-1:0]    idx,
  output logic                valid
);

  // Scan candidates rr_ptr+1 .. rr_ptr+PORT_NUM; the first hit wins.
  always_comb begin : search
    logic [IDX_W-1:0] cand_v;
    logic             hit_v;
    cand_v = '0;
    hit_v  = 1'b0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 1; i <= PORT_NUM; i++) begin
      cand_v         = IDX_W'((int'(rr_ptr) + i) % PORT_NUM);
      hit_v          = req[cand_v] & ~valid;
      onehot[cand_v] = hit_v;
      idx            = hit_v ? cand_v : idx;
      valid          = valid | hit_v;
    end
  end

endmodule

// File: rtl/fifo_bus_sel_arbiter.sv
// FIFO-side responder: grants one frame dispatcher at a time, round-robin and
// packet-locked, and steers the owner's words into the FIFO write port.
module fifo_bus_sel_arbiter
  import fifo_bus_pkg::*;
#(
  parameter int PORT_NUM = PORT_NUM_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORT_NUM-1:0]        req,
  input  logic [PORT_NUM*DATA_W-1:0] fd_data,
  input  logic [PORT_NUM-1:0]        fd_valid,
  input  logic [PORT_NUM-1:0]        fd_eop,
  output logic [PORT_NUM-1:0]        fd_ready,
  output logic [PORT_NUM-1:0]        gnt,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_W-1:0]          fifo_wr_data,
  output logic                       busy,
  output logic                       timeout_pulse
);

  localparam int IDX_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [IDLE_CNT_W-1:0] TMO_LAST = IDLE_CNT_W'(TIMEOUT - 1);

  arb_state_t              state_r;
  arb_state_t              state_nxt_s;
  logic [PORT_NUM-1:0]     gnt_r;
  logic [PORT_NUM-1:0]     gnt_nxt_s;
  logic [IDX_W-1:0]        owner_r;
  logic [IDX_W-1:0]        owner_nxt_s;
  logic [IDX_W-1:0]        rr_ptr_r;
  logic [IDX_W-1:0]        rr_ptr_nxt_s;
  logic [IDLE_CNT_W-1:0]   idle_cnt_r;
  logic [IDLE_CNT_W-1:0]   idle_cnt_nxt_s;

  logic [PORT_NUM-1:0]     pick_onehot_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic                    pick_valid_s;
  logic                    beat_s;
  logic                    release_s;
  logic                    tmo_s;

  rr_pick_onehot #(
    .PORT_NUM (PORT_NUM),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .valid  (pick_valid_s)
  );

  // Owner data path; driven from the registered owner so no input reaches gnt.
  always_comb begin
    fd_ready     = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    beat_s       = 1'b0;
    if (state_r == ST_LOCK) begin
      fd_ready     = gnt_r & {PORT_NUM{~fifo_full}};
      fifo_wr_en   = fd_valid[owner_r] & ~fifo_full;
      fifo_wr_data = fd_data[owner_r*DATA_W +: DATA_W];
      beat_s       = fd_valid[owner_r] & ~fifo_full;
    end else begin
      fd_ready     = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      beat_s       = 1'b0;
    end
  end

  // Grant FSM; an eop or abort release outranks a coinciding timeout.
  always_comb begin
    state_nxt_s    = state_r;
    gnt_nxt_s      = gnt_r;
    owner_nxt_s    = owner_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    idle_cnt_nxt_s = idle_cnt_r;
    release_s      = 1'b0;
    tmo_s          = 1'b0;
    timeout_pulse  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        idle_cnt_nxt_s = '0;
        if (pick_valid_s) begin
          state_nxt_s = ST_LOCK;
          gnt_nxt_s   = pick_onehot_s;
          owner_nxt_s = pick_idx_s;
        end else begin
          gnt_nxt_s   = '0;
        end
      end
      ST_LOCK: begin
        release_s     = (beat_s & fd_eop[owner_r]) | (~req[owner_r] & ~beat_s);
        tmo_s         = ~beat_s & (idle_cnt_r == TMO_LAST);
        timeout_pulse = tmo_s & ~release_s;
        if (release_s | tmo_s) begin
          state_nxt_s    = ST_IDLE;
          gnt_nxt_s      = '0;
          rr_ptr_nxt_s   = owner_r;
          idle_cnt_nxt_s = '0;
        end else if (beat_s) begin
          idle_cnt_nxt_s = '0;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r + IDLE_CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        gnt_nxt_s      = '0;
        idle_cnt_nxt_s = '0;
      end
    endcase
  end

  // State, grant, owner, round-robin pointer and idle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      gnt_r      <= '0;
      owner_r    <= '0;
      rr_ptr_r   <= IDX_W'(PORT_NUM - 1);
      idle_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      gnt_r      <= gnt_nxt_s;
      owner_r    <= owner_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
    end
  end

  assign gnt  = gnt_r;
  assign busy = (state_r == ST_LOCK);

endmodule

// File: tb/tb_fifo_bus_sel_arbiter.sv
// Directed bench for fifo_bus_sel_arbiter with hand-computed expectations.
module tb_fifo_bus_sel_arbiter;

  localparam int PN = 6;
  localparam int DW = 32;
  localparam int TO = 8;

  logic             clk;
  logic             rst_n;
  logic [PN-1:0]    req;
  logic [PN*DW-1:0] fd_data;
  logic [PN-1:0]    fd_valid;
  logic [PN-1:0]    fd_eop;
  logic [PN-1:0]    fd_ready;
  logic [PN-1:0]    gnt;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic             busy;
  logic             timeout_pulse;

  int               n_checks;
  int               n_errors;
  logic [DW-1:0]    wr_log[$];

  fifo_bus_sel_arbiter #(
    .PORT_NUM (PN),
    .DATA_W   (DW),
    .TIMEOUT  (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .fd_data       (fd_data),
    .fd_valid      (fd_valid),
    .fd_eop        (fd_eop),
    .fd_ready      (fd_ready),
    .gnt           (gnt),
    .fifo_full     (fifo_full),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  fifo_bus_sel_arbiter_chk #(.PORT_NUM(PN)) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .gnt   (gnt),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every word the FIFO accepts.
  always @(posedge clk) begin
    if (rst_n && fifo_wr_en) wr_log.push_back(fifo_wr_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int p, input logic [DW-1:0] w);
    fd_data[p*DW +: DW] = w;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req       = '0;
    fd_valid  = '0;
    fd_eop    = '0;
    fd_data   = '0;
    fifo_full = 1'b0;

    // Reset values
    #2;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tmo", 64'(timeout_pulse), 64'd0);
    check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_ready", 64'(fd_ready), 64'd0);
    #5 rst_n = 1'b1;
    tick();

    // Single requester fd_2, three-word packet
    req = 6'b000100; fd_valid = 6'b000100; set_word(2, 32'h2222_0000);
    #1;
    check("t1_gnt_latency", 64'(gnt), 64'd0);
    check("t1_idle_wr_en", 64'(fifo_wr_en), 64'd0);
    tick(); #1;
    check("t1_gnt", 64'(gnt), 64'b000100);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready", 64'(fd_ready), 64'b000100);
    check("t1_wr_en0", 64'(fifo_wr_en), 64'd1);
    check("t1_data0", 64'(fifo_wr_data), 64'h2222_0000);
    tick(); set_word(2, 32'h2222_0001); #1;
    check("t1_wr_en1", 64'(fifo_wr_en), 64'd1);
    tick(); set_word(2, 32'h2222_0002); fd_eop = 6'b000100; #1;
    check("t1_wr_en2", 64'(fifo_wr_en), 64'd1);
    tick(); req = '0; fd_valid = '0; fd_eop = '0; #1;
    check("t1_gnt_after_eop", 64'(gnt), 64'd0);
    check("t1_busy_after_eop", 64'(busy), 64'd0);
    check("t1_beats", 64'(wr_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < wr_log.size(); i++)
      check("t1_word", 64'(wr_log[i]), 64'h2222_0000 + 64'(i));
    wr_log.delete();

    // Fresh reset so rr_ptr is back at PORT_NUM-1
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();

    // Round robin between fd_0 and fd_5, two-word packets
    req = 6'b100001; fd_valid = 6'b100001;
    set_word(0, 32'h0A0A_0000); set_word(5, 32'h0505_0000);
    #1;
    check("t2_idle", 64'(gnt), 64'd0);
    tick(); #1;
    check("t2_gnt_fd0", 64'(gnt), 64'b000001);
    check("t2_data_fd0", 64'(fifo_wr_data), 64'h0A0A_0000);
    check("t2_ready_fd0", 64'(fd_ready), 64'b000001);
    tick(); fd_eop = 6'b100001; #1;
    check("t2_hold_fd0", 64'(gnt), 64'b000001);
    tick(); fd_eop = '0; #1;
    check("t2_gap1", 64'(gnt), 64'd0);
    check("t2_gap1_busy", 64'(busy), 64'd0);
    tick(); #1;
    check("t2_gnt_fd5", 64'(gnt), 64'b100000);
    check("t2_data_fd5", 64'(fifo_wr_data), 64'h0505_0000);
    tick(); fd_eop = 6'b100001; #1;
    check("t2_hold_fd5", 64'(gnt), 64'b100000);
    tick(); fd_eop = '0; #1;
    check("t2_gap2", 64'(gnt), 64'd0);
    tick(); #1;
    check("t2_gnt_fd0_again", 64'(gnt), 64'b000001);
    // Owner drops req with no beat: abort, no timeout pulse
    req = '0; fd_valid = '0; #1;
    check("t2_abort_wr_en", 64'(fifo_wr_en), 64'd0);
    check("t2_abort_tmo", 64'(timeout_pulse), 64'd0);
    tick(); #1;
    check("t2_abort_gnt", 64'(gnt), 64'd0);
    check("t2_abort_tmo_after", 64'(timeout_pulse), 64'd0);
    check("t2_beats", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() == 4) begin
      check("t2_word1", 64'(wr_log[1]), 64'h0A0A_0000);
      check("t2_word2", 64'(wr_log[2]), 64'h0505_0000);
    end else begin
      check("t2_words_present", 64'(wr_log.size()), 64'd4);
    end
    wr_log.delete();

    // fd_1 owner, FIFO full for 4 cycles mid-packet
    req = 6'b000010; fd_valid = 6'b000010; set_word(1, 32'h1111_0000);
    tick(); #1;
    check("t3_gnt", 64'(gnt), 64'b000010);
    check("t3_data0", 64'(fifo_wr_data), 64'h1111_0000);
    tick(); set_word(1, 32'h1111_0001); #1;
    check("t3_data1", 64'(fifo_wr_data), 64'h1111_0001);
    tick(); set_word(1, 32'h1111_0002); fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_stall_ready", 64'(fd_ready), 64'd0);
      check("t3_stall_wr_en", 64'(fifo_wr_en), 64'd0);
      check("t3_stall_gnt", 64'(gnt), 64'b000010);
      tick();
    end
    fifo_full = 1'b0; #1;
    check("t3_resume_wr_en", 64'(fifo_wr_en), 64'd1);
    check("t3_resume_data", 64'(fifo_wr_data), 64'h1111_0002);
    check("t3_resume_ready", 64'(fd_ready), 64'b000010);
    tick(); set_word(1, 32'h1111_0003); fd_eop = 6'b000010; #1;
    check("t3_last_wr_en", 64'(fifo_wr_en), 64'd1);
    tick(); req = '0; fd_valid = '0; fd_eop = '0; #1;
    check("t3_released", 64'(gnt), 64'd0);
    check("t3_beats", 64'(wr_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      check("t3_word", 64'(wr_log[i]), 64'h1111_0000 + 64'(i));
    wr_log.delete();

    // Timeout: fd_3 owns with nothing to send, fd_4 waiting
    req = 6'b011000; fd_valid = '0;
    tick();
    for (int k = 1; k < TO; k++) begin
      #1;
      check("t4_gnt_fd3", 64'(gnt), 64'b001000);
      check("t4_no_tmo", 64'(timeout_pulse), 64'd0);
      tick();
    end
    #1;
    check("t4_tmo_pulse", 64'(timeout_pulse), 64'd1);
    check("t4_gnt_at_tmo", 64'(gnt), 64'b001000);
    tick(); #1;
    check("t4_gnt_revoked", 64'(gnt), 64'd0);
    check("t4_pulse_gone", 64'(timeout_pulse), 64'd0);
    tick(); #1;
    check("t4_gnt_fd4", 64'(gnt), 64'b010000);

    // Reset mid-packet drops the grant at once
    fd_valid = 6'b010000; set_word(4, 32'h4444_0000); #1;
    check("t5_wr_en", 64'(fifo_wr_en), 64'd1);
    tick(); #2;
    rst_n = 1'b0; #1;
    check("t5_rst_gnt", 64'(gnt), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_wr_en", 64'(fifo_wr_en), 64'd0);
    check("t5_rst_ready", 64'(fd_ready), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
